// File: rtl/risc_cpu_pkg.sv
// rtl/risc_cpu_pkg.sv - opcode and FSM state encodings shared by the CPU core
package risc_cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC_RD = 3'd2,
        ST_EXEC_WR = 3'd3,
        ST_HALTED  = 3'd4
    } state_t;

endpackage

// File: rtl/risc_cpu_core_p_alu.sv
// rtl/risc_cpu_core_p_alu.sv - combinational accumulator update for memory-operand opcodes
module risc_alu
    import risc_cpu_pkg::*;
#(
    parameter int WIDTH_REG = 8
) (
    input  logic [2:0]           opcode,
    input  logic [WIDTH_REG-1:0] acc,
    input  logic [WIDTH_REG-1:0] rdata,
    output logic [WIDTH_REG-1:0] acc_next
);

    always_comb begin
        acc_next = acc;
        case (opcode)
            OP_ADD:  acc_next = acc + rdata;
            OP_AND:  acc_next = acc & rdata;
            OP_XOR:  acc_next = acc ^ rdata;
            OP_LDA:  acc_next = rdata;
            default: acc_next = acc;
        endcase
    end

endmodule

// File: rtl/risc_cpu_core_p.sv
// rtl/risc_cpu_core_p.sv - multicycle accumulator CPU with req/ack memory port, bus timeout and resume
module risc_cpu_core_p
    import risc_cpu_pkg::*;
#(
    parameter int WIDTH_REG  = 8,
    parameter int OPCODE     = 3,
    parameter int MAX_WAIT   = 15,
    localparam int ADDR_WIDTH = WIDTH_REG - OPCODE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  resume,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH_REG-1:0]  mem_wdata,
    input  logic [WIDTH_REG-1:0]  mem_rdata,
    input  logic                  mem_ack,
    output logic [WIDTH_REG-1:0]  result,
    output logic [ADDR_WIDTH-1:0] pcc,
    output logic                  zero,
    output logic                  HALT,
    output logic                  bus_err,
    output logic [2:0]            state_dbg
);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [WIDTH_REG-1:0]  acc;
    logic [WIDTH_REG-1:0]  ir;
    logic [7:0]            wait_cnt;
    logic [2:0]            opcode;
    logic [ADDR_WIDTH-1:0] operand;
    logic [WIDTH_REG-1:0]  alu_out;
    logic                  req_state;
    logic                  timeout;

    assign opcode    = 3'(ir[WIDTH_REG-1 -: OPCODE]);
    assign operand   = ir[ADDR_WIDTH-1:0];
    assign req_state = (state == ST_FETCH) || (state == ST_EXEC_RD) || (state == ST_EXEC_WR);
    // An ack in the final allowed cycle wins over the timeout.
    assign timeout   = req_state && !mem_ack && (wait_cnt == 8'(MAX_WAIT - 1));

    risc_alu #(.WIDTH_REG(WIDTH_REG)) u_alu (
        .opcode   (opcode),
        .acc      (acc),
        .rdata    (mem_rdata),
        .acc_next (alu_out)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (mem_ack)      state_next = ST_DECODE;
                else if (timeout) state_next = ST_HALTED;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_HLT:         state_next = ST_HALTED;
                    OP_SKZ, OP_JMP: state_next = ST_FETCH;
                    OP_STO:         state_next = ST_EXEC_WR;
                    default:        state_next = ST_EXEC_RD;
                endcase
            end
            ST_EXEC_RD, ST_EXEC_WR: begin
                if (mem_ack)      state_next = ST_FETCH;
                else if (timeout) state_next = ST_HALTED;
            end
            ST_HALTED: begin
                if (resume) state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_FETCH;
            pc       <= '0;
            acc      <= '0;
            ir       <= '0;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_next;
            // Every exit from a request state goes through ack or timeout, so this also clears on entry.
            if (req_state && !mem_ack && !timeout) wait_cnt <= wait_cnt + 8'd1;
            else                                   wait_cnt <= '0;
            if (timeout)                           bus_err <= 1'b1;
            else if (state == ST_HALTED && resume) bus_err <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_WIDTH'(1);
                    end
                end
                ST_DECODE: begin
                    if (opcode == OP_SKZ && zero) pc <= pc + ADDR_WIDTH'(1);
                    else if (opcode == OP_JMP)    pc <= operand;
                end
                ST_EXEC_RD: begin
                    if (mem_ack) acc <= alu_out;
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = reset && req_state;
    assign mem_we    = (state == ST_EXEC_WR);
    assign mem_addr  = (state == ST_FETCH) ? pc : operand;
    assign mem_wdata = acc;
    assign result    = acc;
    assign pcc       = pc;
    assign zero      = (acc == '0);
    assign HALT      = (state == ST_HALTED);
    assign state_dbg = state;

endmodule

// File: tb/tb_risc_cpu_core_p.sv
// tb/tb_risc_cpu_core_p.sv - scoreboard bench: memory model with wait states, expected results and writes queued per program
module tb_risc_cpu_core_p;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       resume = 1'b0;
    logic       mem_req, mem_we, mem_ack = 1'b0;
    logic [4:0] mem_addr, pcc;
    logic [7:0] mem_wdata, mem_rdata = 8'h00, result;
    logic       zero, HALT, bus_err;
    logic [2:0] state_dbg;

    risc_cpu_core_p dut (
        .clk(clk), .reset(reset), .resume(resume),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .result(result), .pcc(pcc), .zero(zero), .HALT(HALT), .bus_err(bus_err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [32];
    logic [31:0] fetched;
    int          ack_delay = 0;
    logic        no_ack = 1'b0;
    int          req_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_res [$];
    logic [12:0] exp_wr [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model and scoreboard: ack decided at the falling edge, held across the rising edge.
    initial begin
        int         wcnt;
        logic       pend;
        logic       in_wait;
        logic [13:0] prev;
        wcnt = 0; pend = 1'b0; in_wait = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (exp_res.size() == 0) chk("res_unexpected", 32'(result), 32'hFFFF_FFFF);
                else                     chk("result", 32'(result), 32'(exp_res.pop_front()));
                pend = 1'b0;
            end
            mem_ack = 1'b0;
            if (mem_req) begin
                req_cnt++;
                if (in_wait) chk("req_stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(prev));
                prev = {mem_we, mem_addr, mem_wdata};
                if (!no_ack && wcnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    wcnt = 0;
                    in_wait = 1'b0;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        if (exp_wr.size() == 0) chk("wr_unexpected", 32'({mem_addr, mem_wdata}), 32'hFFFF_FFFF);
                        else                    chk("write", 32'({mem_addr, mem_wdata}), 32'(exp_wr.pop_front()));
                    end else if (state_dbg == 3'd0) begin
                        fetched[mem_addr] = 1'b1;
                    end else begin
                        pend = 1'b1;
                    end
                end else begin
                    wcnt++;
                    in_wait = 1'b1;
                end
            end else begin
                wcnt = 0;
                in_wait = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        fetched = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        chk("rst_req_now", 32'(mem_req), 0);
        repeat (3) begin
            tick();
            chk("rst_req", 32'(mem_req), 0);
        end
        chk("rst_result", 32'(result), 0);
        chk("rst_pcc", 32'(pcc), 0);
        chk("rst_halt", 32'(HALT), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_state", 32'(state_dbg), 0);
    endtask

    task automatic release_reset();
        reset = 1'b1;
        #1;
        chk("first_req", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 5'd0}));
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (!HALT && n < budget) begin
            tick();
            n++;
        end
        chk("halt_reached", 32'(HALT), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Arithmetic program with zero-wait memory.
        clear_mem();
        mem[0] = 8'hB4; mem[20] = 8'd7;
        mem[1] = 8'h55; mem[21] = 8'd250;
        mem[2] = 8'hD6; mem[3] = 8'h00;
        exp_res.push_back(8'd7);
        exp_res.push_back(8'd1);
        exp_wr.push_back({5'd22, 8'd1});
        apply_reset();
        release_reset();
        repeat (10) tick();
        chk("arith_halt_c10", 32'(HALT), 0);
        tick();
        chk("arith_halt_c11", 32'(HALT), 1);
        chk("arith_pcc", 32'(pcc), 4);
        chk("arith_result", 32'(result), 1);
        chk("arith_mem22", 32'(mem[22]), 1);
        chk("arith_zero", 32'(zero), 0);

        // SKZ skip, JMP to top address, pc wrap.
        clear_mem();
        mem[0] = 8'hB4; mem[20] = 8'd0;
        mem[1] = 8'h20; mem[2] = 8'h00;
        mem[3] = 8'hFF; mem[31] = 8'h00;
        exp_res.push_back(8'd0);
        apply_reset();
        release_reset();
        wait_halt(40);
        chk("skz_pcc_wrap", 32'(pcc), 0);
        chk("skz_no_fetch2", 32'(fetched[2]), 0);
        chk("jmp_fetch31", 32'(fetched[31]), 1);
        chk("skz_zero", 32'(zero), 1);

        // Wait states: three idle cycles before every ack.
        clear_mem();
        ack_delay = 3;
        mem[0] = 8'hB4; mem[20] = 8'h5A; mem[1] = 8'h00;
        exp_res.push_back(8'h5A);
        apply_reset();
        release_reset();
        repeat (8) tick();
        chk("wait_c8_state", 32'(state_dbg), 2);
        chk("wait_c8_result", 32'(result), 0);
        tick();
        chk("wait_c9_state", 32'(state_dbg), 0);
        chk("wait_c9_result", 32'(result), 32'h5A);
        wait_halt(40);
        chk("wait_pcc", 32'(pcc), 2);

        // Timeout: no ack ever, then resume into a HLT program.
        clear_mem();
        ack_delay = 0;
        no_ack = 1'b1;
        apply_reset();
        req_cnt = 0;
        release_reset();
        wait_halt(40);
        chk("tmo_req_cycles", 32'(req_cnt), 15);
        chk("tmo_bus_err", 32'(bus_err), 1);
        chk("tmo_pcc", 32'(pcc), 0);
        chk("tmo_req_low", 32'(mem_req), 0);
        no_ack = 1'b0;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_bus_err", 32'(bus_err), 0);
        chk("resume_req", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 5'd0}));
        chk("resume_state", 32'(state_dbg), 0);
        wait_halt(10);
        chk("resume_pcc", 32'(pcc), 1);

        // Reset asserted during an EXEC_RD wait.
        clear_mem();
        ack_delay = 3;
        mem[0] = 8'hB4; mem[20] = 8'd9;
        mem[1] = 8'hB5; mem[21] = 8'd3;
        exp_res.push_back(8'd9);
        apply_reset();
        release_reset();
        repeat (15) tick();
        chk("mid_state", 32'(state_dbg), 2);
        chk("mid_result", 32'(result), 9);
        chk("mid_req", 32'(mem_req), 1);
        reset = 1'b0;
        #1;
        chk("mid_req_gated", 32'(mem_req), 0);
        tick();
        chk("mid_pcc", 32'(pcc), 0);
        chk("mid_result_rst", 32'(result), 0);
        chk("mid_state_rst", 32'(state_dbg), 0);
        reset = 1'b1;
        ack_delay = 0;
        repeat (3) tick();

        chk("exp_res_drained", 32'(exp_res.size()), 0);
        chk("exp_wr_drained", 32'(exp_wr.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/risc_cpu_core_p.md
Name: risc_cpu_core_p

Overview:
- Parametrised multicycle accumulator CPU core; the next generation of the team's 8-bit RISC CPU, generalised in data width.
- Fetches instructions and operands over a shared req/ack memory port that tolerates wait states.
- Adds a bus timeout with error halt, and a resume input that restarts the core after HLT or after a bus error.
- Instantiated by the system top; memory sits outside, on the memory port.

Parameters:
- WIDTH_REG, 8: data, accumulator and instruction width.
- OPCODE, 3: opcode field width, taken from the instruction MSBs. Fixed opcode set of 8.
- MAX_WAIT, 15: maximum cycles a memory request may stay unacknowledged. Legal range 1..255.
- ADDR_WIDTH: localparam = WIDTH_REG-OPCODE (5 by default).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- resume  in  1  single-cycle pulse; leaves HALTED.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write, 0=read; valid while mem_req=1.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_wdata  out  WIDTH_REG  write data (the accumulator).
- mem_rdata  in  WIDTH_REG  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  completes the current request; ignored when mem_req=0.
- result  out  WIDTH_REG  accumulator.
- pcc  out  ADDR_WIDTH  program counter.
- zero  out  1  combinational (result==0).
- HALT  out  1  core is in HALTED.
- bus_err  out  1  sticky; set on timeout.
- state_dbg  out  3  current FSM state encoding.

Behaviour:
- Instruction word: opcode = [WIDTH_REG-1 -: OPCODE]; operand address = [ADDR_WIDTH-1:0].
- Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- Reset (reset=0 at a clock edge):
  - pc=0, acc=0, ir=0, wait_cnt=0, bus_err=0, state=FETCH.
  - mem_req is gated by reset and reads 0 combinationally while reset=0, including when reset is asserted mid-request; any in-flight transaction is abandoned.
  - First request appears in the first cycle with reset=1.
- States: FETCH, DECODE, EXEC_RD, EXEC_WR, HALTED.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On ack: ir<=mem_rdata, pc<=pc+1 (wraps mod 2^ADDR_WIDTH), go to DECODE.
- DECODE: one cycle, no request.
  - HLT: go to HALTED.
  - SKZ: if zero, pc<=pc+1 (wraps); go to FETCH.
  - JMP: pc<=operand; go to FETCH.
  - ADD/AND/XOR/LDA: go to EXEC_RD.
  - STO: go to EXEC_WR.
- EXEC_RD:
  - mem_req=1, mem_we=0, mem_addr=operand.
  - On ack: acc<=acc+rdata (mod 2^WIDTH_REG, carry discarded), acc&rdata, acc^rdata, or rdata, per opcode; go to FETCH.
- EXEC_WR:
  - mem_req=1, mem_we=1, mem_addr=operand, mem_wdata=acc.
  - On ack: go to FETCH.
- Request stability: mem_req, mem_we, mem_addr and mem_wdata stay constant from the first request cycle until the ack cycle.
- Latency with zero-wait ack: 2 cycles for HLT/SKZ/JMP; 3 cycles for the others. Each wait cycle adds 1.
- Timeout:
  - wait_cnt clears on entry to any request state and increments each request cycle without ack.
  - A request cycle with no ack and wait_cnt==MAX_WAIT-1 moves to HALTED with bus_err<=1. mem_req is therefore high for exactly MAX_WAIT cycles.
  - An ack in that last cycle takes priority over the timeout.
- HALTED:
  - HALT=1; mem_req=0; pc and acc held.
  - resume=1 goes to FETCH at the current pc and clears bus_err.
  - After an EXEC timeout, the interrupted instruction is not retried.
  - resume is ignored in every other state.
- reset has priority over resume and over mem_ack.

Decomposition:
- Package risc_cpu_pkg: opcode localparams (OP_HLT..OP_JMP) and state encodings (ST_FETCH..ST_HALTED).
- Sub-module risc_alu: combinational; inputs opcode, acc, rdata; output next acc. Parametrised by WIDTH_REG.
- FSM, pc, ir, wait counter and memory port stay in the top.

Test Plan:
- Reset and first fetch:
  - Hold reset=0 for 3 cycles -> mem_req=0 throughout, result=0, pcc=0, HALT=0.
  - Release reset -> next cycle mem_req=1, mem_we=0, mem_addr=0.
- Arithmetic program, zero-wait ack:
  - mem[0]=8'hB4 (LDA 20), mem[20]=7, mem[1]=8'h55 (ADD 21), mem[21]=250, mem[2]=8'hD6 (STO 22), mem[3]=8'h00.
  - Expect result=7, then result=1 (wrap); write of 1 to address 22; HALT=1 on cycle 11 after reset release; pcc=4.
- SKZ/JMP and pc wrap:
  - mem[0]=8'hB4, mem[20]=0, mem[1]=8'h20 (SKZ), mem[2]=8'h00, mem[3]=8'hFF (JMP 31), mem[31]=8'h00.
  - Expect address 2 never fetched; HALT=1 with pcc=0.
- Wait states:
  - ack delayed 3 cycles on every request; LDA 20.
  - Expect request signals stable during the wait; LDA completes in 9 cycles; result=mem[20].
- Timeout and resume:
  - Never ack -> mem_req high exactly 15 cycles, then HALT=1, bus_err=1, pcc=0.
  - Pulse resume -> bus_err=0, refetch at address 0.
- Reset mid-wait:
  - Assert reset during an EXEC_RD wait -> mem_req=0 in the same cycle.
  - After the edge: pcc=0, result=0, state_dbg=FETCH encoding.
